// File: rtl/seg7_scan_ctrl_if.sv
// Bus between a display-data producer and the seven-segment scan controller:
// frame data and strobes in, registered anode/segment drive and frame status out.
interface seg7_scan_ctrl_if #(
  parameter int N_DIGITS = 8
);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [4*N_DIGITS-1:0] digits_i;
  logic [N_DIGITS-1:0]   dp_i;
  logic [N_DIGITS-1:0]   en_i;
  logic                  load_i;
  logic                  blank_i;
  logic [N_DIGITS-1:0]   an;
  logic [6:0]            seg;
  logic                  dp;
  logic [IDX_W-1:0]      digit_idx;
  logic                  frame_done;

  modport master (
    output digits_i, dp_i, en_i, load_i, blank_i,
    input  an, seg, dp, digit_idx, frame_done
  );

  modport slave (
    input  digits_i, dp_i, en_i, load_i, blank_i,
    output an, seg, dp, digit_idx, frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scanner: fixed-length digit slots, anti-ghosting
// dead time at each slot start, and frame-synchronous double-buffered display data.
module seg7_scan_ctrl #(
  parameter int N_DIGITS     = 8,
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst,
  seg7_scan_ctrl_if.slave bus
);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_W = $clog2(CLK_DIV);

  typedef enum logic {S_BLANK, S_DRIVE} state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt;
  state_t                r_state, w_state_nxt;
  logic                  w_slot_end, w_wrap;

  logic [4*N_DIGITS-1:0] r_act_dig, w_act_dig_nxt, r_pnd_dig;
  logic [N_DIGITS-1:0]   r_act_dp, w_act_dp_nxt, r_pnd_dp;
  logic [N_DIGITS-1:0]   r_act_en, w_act_en_nxt, r_pnd_en;
  logic                  r_pnd_vld;

  logic [3:0]            w_nib;
  logic [N_DIGITS-1:0]   r_an, w_an_nxt;
  logic [6:0]            r_seg, w_seg_nxt;
  logic                  r_dp, w_dp_nxt;
  logic                  r_frame_done;

  always_comb begin
    w_slot_end = (r_cnt == CNT_W'(CLK_DIV - 1));
    w_wrap     = w_slot_end && (r_idx == IDX_W'(N_DIGITS - 1));
    w_cnt_nxt  = w_slot_end ? '0 : r_cnt + CNT_W'(1);
    w_idx_nxt  = r_idx;
    if (w_slot_end) w_idx_nxt = w_wrap ? '0 : r_idx + IDX_W'(1);

    w_state_nxt = r_state;
    case (r_state)
      S_BLANK: if (BLANK_CYCLES == 0 || r_cnt == CNT_W'(BLANK_CYCLES - 1)) w_state_nxt = S_DRIVE;
      S_DRIVE: if (w_slot_end && BLANK_CYCLES != 0) w_state_nxt = S_BLANK;
      default: w_state_nxt = S_BLANK;
    endcase

    // A load coincident with the wrap bypasses the pending buffer.
    w_act_dig_nxt = r_act_dig;
    w_act_dp_nxt  = r_act_dp;
    w_act_en_nxt  = r_act_en;
    if (w_wrap && bus.load_i) begin
      w_act_dig_nxt = bus.digits_i;
      w_act_dp_nxt  = bus.dp_i;
      w_act_en_nxt  = bus.en_i;
    end else if (w_wrap && r_pnd_vld) begin
      w_act_dig_nxt = r_pnd_dig;
      w_act_dp_nxt  = r_pnd_dp;
      w_act_en_nxt  = r_pnd_en;
    end

    // Outputs are computed from next-state values so the registered drive lines up with the slot.
    w_nib     = w_act_dig_nxt[int'(w_idx_nxt)*4 +: 4];
    w_an_nxt  = '1;
    w_seg_nxt = 7'h7F;
    w_dp_nxt  = 1'b1;
    if (w_state_nxt == S_DRIVE) begin
      w_seg_nxt = seg_decode(w_nib);
      w_dp_nxt  = ~w_act_dp_nxt[w_idx_nxt];
      if (w_act_en_nxt[w_idx_nxt] && !bus.blank_i) w_an_nxt[w_idx_nxt] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_state      <= S_BLANK;
      r_act_dig    <= '0;
      r_act_dp     <= '0;
      r_act_en     <= '0;
      r_pnd_vld    <= 1'b0;
      r_an         <= '1;
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_state      <= w_state_nxt;
      r_act_dig    <= w_act_dig_nxt;
      r_act_dp     <= w_act_dp_nxt;
      r_act_en     <= w_act_en_nxt;
      if (bus.load_i && !w_wrap) r_pnd_vld <= 1'b1;
      else if (w_wrap)           r_pnd_vld <= 1'b0;
      r_an         <= w_an_nxt;
      r_seg        <= w_seg_nxt;
      r_dp         <= w_dp_nxt;
      r_frame_done <= w_wrap;
    end
  end

  // Pending data is qualified by r_pnd_vld, so it carries no reset.
  always_ff @(posedge clk) begin
    if (rst && bus.load_i && !w_wrap) begin
      r_pnd_dig <= bus.digits_i;
      r_pnd_dp  <= bus.dp_i;
      r_pnd_en  <= bus.en_i;
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.digit_idx  = r_idx;
  assign bus.frame_done = r_frame_done;
endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter N_DIGITS, default 8, number of multiplexed digits (legal 1..8).
REQ-002 Parameter CLK_DIV, default 100000, clk cycles per digit slot (legal >= 2).
REQ-003 Parameter BLANK_CYCLES, default 16, anti-ghosting dead time at slot start (legal 0..CLK_DIV-1).
REQ-004 clk  in  1  rising-edge system clock.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 digits_i  in  4*N_DIGITS  hex nibble per digit; digit k at bits [4k+3:4k].
REQ-007 dp_i  in  N_DIGITS  decimal point request per digit, 1 = lit.
REQ-008 en_i  in  N_DIGITS  digit enable mask, 1 = digit shown.
REQ-009 load_i  in  1  single-cycle strobe capturing digits_i/dp_i/en_i into the pending register.
REQ-010 blank_i  in  1  level; 1 forces all anodes off while scanning continues.
REQ-011 an  out  N_DIGITS  anode drive, active-low, one-hot-low or all ones.
REQ-012 seg  out  7  segments gfedcba, active-low.
REQ-013 dp  out  1  decimal point, active-low.
REQ-014 digit_idx  out  $clog2(N_DIGITS) (min 1)  index of current slot.
REQ-015 frame_done  out  1  one-cycle pulse on the first cycle of slot 0.

Function
REQ-016 Slot counter cnt SHALL count 0..CLK_DIV-1 every cycle; at CLK_DIV-1 it SHALL return to 0 and digit_idx SHALL advance, wrapping N_DIGITS-1 -> 0.
REQ-017 FSM states BLANK, DRIVE: slot starts in BLANK; BLANK -> DRIVE when cnt==BLANK_CYCLES-1; DRIVE -> BLANK at slot end; BLANK_CYCLES=0 SHALL keep FSM permanently in DRIVE.
REQ-018 In BLANK, an SHALL be all ones and seg SHALL be 7'h7F, dp 1.
REQ-019 In DRIVE, an[digit_idx] SHALL be 0, all other bits 1, if active enable bit is 1 and blank_i is 0; otherwise an all ones.
REQ-020 seg SHALL decode the active nibble of digit_idx: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E (hex); dp = ~active dp bit.
REQ-021 All outputs SHALL be registered; no combinational path from any input to any output; blank_i takes effect on the cycle after it is sampled.
REQ-022 Disabled digits SHALL still consume their full slot (constant frame period N_DIGITS*CLK_DIV).
REQ-023 load_i SHALL copy inputs into pending registers and set a pending flag; a later load_i before a wrap SHALL overwrite pending values.
REQ-024 At the edge where digit_idx wraps to 0, if pending flag set, active registers SHALL take the pending values and the flag SHALL clear; display data SHALL never change mid-frame.
REQ-025 load_i coincident with the wrap edge SHALL be applied directly at that wrap (input values win over older pending values).
REQ-026 frame_done SHALL assert for exactly the first cycle after every wrap; N_DIGITS=1 SHALL pulse every slot.

Reset
REQ-027 While rst=0 at a clock edge: an all ones, seg 7'h7F, dp 1, digit_idx 0, cnt 0, FSM BLANK, frame_done 0, active digits/dp/en 0, pending flag 0.
REQ-028 Reset mid-operation SHALL discard pending data; load_i sampled with rst=0 SHALL be ignored; first frame_done SHALL occur at the first wrap after release.

Verification (N_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2)
REQ-029 rst=0 for 5 cycles -> an=4'hF, seg=7'h7F, dp=1, digit_idx=0, frame_done=0; after release an stays 4'hF (enable 0).
REQ-030 load digits_i=16'h3210, en_i=4'hF, dp_i=4'b0001 -> from next wrap: each slot 2 cycles an=4'hF then 6 cycles; slot0 an=4'b1110 seg=7'h40 dp=0; slot1 an=4'b1101 seg=7'h79 dp=1; slot2 seg=7'h24; slot3 seg=7'h30.
REQ-031 en_i=4'b1011 loaded -> slot 2 an=4'hF all 8 cycles; frame_done spacing stays 32 cycles.
REQ-032 load mid-slot-1 with 16'hFFFF -> seg unchanged until wrap, then 7'h0E for all slots; load exactly on wrap edge -> applied at that wrap.
REQ-033 rst=0 during DRIVE of slot 2 with pending load -> next cycle all reset values; after release old pending data never appears.
REQ-034 blank_i=1 for 40 cycles -> an=4'hF from cycle after assertion, digit_idx keeps advancing, frame_done still every 32 cycles.
